imem_responder: RTL



---
 rtl/imem_pkg.sv | 34 +++
 rtl/imem_array.sv | 36 +++
 rtl/imem_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory responder and, later, the
// data-memory responder on the LSU side.
//   state_t           : responder FSM encoding (2 bits)
//   DEFAULT_BASE_ADDR : byte address of word 0 unless overridden
//   RSP_ERR_W         : width of the response error code
//   addr_decode_err() : misalignment / range check shared by responders
// -----------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

    localparam int RSP_ERR_W = 1;

    // The offset is computed with 32-bit wrap, so addresses below the base
    // become huge offsets and fall out of range through the same compare.
    function automatic logic addr_decode_err(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] span_bytes
    );
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || (off >= span_bytes);
    endfunction

endpackage : imem_pkg

// File: rtl/imem_array.sv
// -----------------------------------------------------------------------------
// imem_array
// DEPTH x 32 word storage. Synchronous write, combinational read.
// A read of the same index on the write edge returns the old word, because
// the read path looks at the array before the edge updates it.
// Contents are not reset.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write word index
//   i_wdata : write data
//   i_raddr : read word index
//   o_rdata : read data (combinational)
// -----------------------------------------------------------------------------
module imem_array #(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : imem_array

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
// Memory-side responder for the instruction-fetch handshake. Accepts one
// word read at a time, waits LATENCY cycles, then presents the response and
// holds it until the consumer takes it.
//
// Handshake rules: a transfer happens on a rising edge where valid && ready
// are both high. The responder raises req_ready only in IDLE and holds
// rsp_valid/rsp_data/rsp_err stable in RESP until rsp_ready is seen. The
// consumer may drop req_valid before acceptance; nothing is recorded then.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake
//   req_addr             : byte address of requested word
//   rsp_valid/rsp_ready  : response handshake
//   rsp_data             : instruction word (0 on error)
//   rsp_err              : misaligned or out-of-range request
//   ld_en/ld_addr/ld_data: side load port into the word array
//   dbg_state            : current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [RSP_ERR_W-1:0] rsp_err,
    input  logic                 ld_en,
    input  logic [AW-1:0]        ld_addr,
    input  logic [31:0]          ld_data,
    output logic [1:0]           dbg_state
);

    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH * 4);
    localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_rsp_data;
    logic          r_rsp_err;

    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_err;
    logic [31:0]   w_rdata;
    logic          w_accept;
    logic          w_rsp_done;

    // ---------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------
    assign w_off = req_addr - BASE_ADDR;
    assign w_idx = w_off[AW+1:2];
    assign w_err = addr_decode_err(req_addr, BASE_ADDR, SPAN_BYTES);

    imem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_we    (ld_en),
        .i_waddr (ld_addr),
        .i_wdata (ld_data),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    assign w_accept   = (r_state == ST_IDLE) && req_valid;
    assign w_rsp_done = (r_state == ST_RESP) && rsp_ready;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_rsp_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: req_ready = 1'b1;
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign dbg_state = r_state;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

    // ---------------------------------------------------------------------
    // Latency counter and captured response. Data is sampled at the accept
    // edge, so later loads never disturb an in-flight response.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 4'd0;
            r_rsp_data <= 32'd0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt      <= CNT_INIT;
                r_rsp_data <= w_err ? 32'd0 : w_rdata;
                r_rsp_err  <= w_err;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

endmodule : imem_responder
